// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: rs/rt forwarding selects, RAW/load-use stall,
// mult/div sequencer with HI/LO write pulse and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int FWD_EN  = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic             i_id_kill,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_use_rs,
    input  logic             i_id_use_rt,
    input  logic             i_id_md_start,
    input  logic             i_id_md_div,
    input  logic             i_id_md_read,
    input  logic             i_ex_wreg,
    input  logic             i_ex_load,
    input  logic [4:0]       i_ex_rn,
    input  logic             i_mem_wreg,
    input  logic             i_mem_load,
    input  logic [4:0]       i_mem_rn,
    input  logic             i_perf_clr,
    output logic [1:0]       o_fwda,
    output logic [1:0]       o_fwdb,
    output logic             o_stall,
    output logic             o_md_issue,
    output logic             o_md_busy,
    output logic             o_md_done,
    output logic             o_md_is_div,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_is_div;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_live;
    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b;
    logic w_load_use, w_raw, w_md_haz;
    logic w_stall, w_issue;

    assign w_live = i_id_valid & ~i_id_kill;

    // r0 never matches, so it is never forwarded nor stalled on
    assign w_ex_a  = i_id_use_rs & i_ex_wreg & (i_ex_rn != 5'd0) & (i_ex_rn == i_id_rs);
    assign w_ex_b  = i_id_use_rt & i_ex_wreg & (i_ex_rn != 5'd0) & (i_ex_rn == i_id_rt);
    assign w_mem_a = i_id_use_rs & i_mem_wreg & (i_mem_rn != 5'd0) & (i_mem_rn == i_id_rs);
    assign w_mem_b = i_id_use_rt & i_mem_wreg & (i_mem_rn != 5'd0) & (i_mem_rn == i_id_rt);

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                           input logic ex_ld, input logic mem_ld);
        if (ex_hit && !ex_ld)
            return 2'b01;
        else if (mem_hit)
            return mem_ld ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        o_fwda     = 2'b00;
        o_fwdb     = 2'b00;
        w_load_use = 1'b0;
        w_raw      = 1'b0;
        if (FWD_EN != 0) begin
            o_fwda     = fwd_sel(w_ex_a, w_mem_a, i_ex_load, i_mem_load);
            o_fwdb     = fwd_sel(w_ex_b, w_mem_b, i_ex_load, i_mem_load);
            w_load_use = (w_ex_a | w_ex_b) & i_ex_load;
        end else begin
            w_raw = w_ex_a | w_ex_b | w_mem_a | w_mem_b;
        end
    end

    assign w_md_haz = (i_id_md_start | i_id_md_read) & (r_state != S_IDLE);
    assign w_stall  = w_live & (w_load_use | w_raw | w_md_haz);
    assign w_issue  = w_live & i_id_md_start & ~w_stall;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state  <= S_BUSY;
                        r_busy   <= 1'b1;
                        r_cnt    <= i_id_md_div ? DIV_M1 : MUL_M1;
                        r_is_div <= i_id_md_div;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_stall_cycles <= '0;
        else if (i_perf_clr)
            r_stall_cycles <= '0;
        else if (w_stall && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign o_stall        = w_stall;
    assign o_md_issue     = w_issue;
    assign o_md_busy      = r_busy;
    assign o_md_done      = r_done;
    assign o_md_is_div    = r_is_div;
    assign o_stall_cycles = r_stall_cycles;

endmodule
